// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state type and scan-code constants for the PS/2 receiver
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_NONE = 8'h00;
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: synchronises ps2_clk/ps2_data and flags ps2_clk falling edges
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  input logic ps2_clk,
  input logic ps2_data,
  output logic fall,
  output logic data_s
);
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic clk_prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '1;
      data_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end
  assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
endmodule

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: PS/2 frame receiver with make/break tracking; define PS2_EXTENDED_EN to swallow E0-prefixed keys
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input logic clk,
  input logic rst,
  input logic ps2_clk,
  input logic ps2_data,
  output logic [7:0] keyboard_data,
  output logic code_valid,
  output logic frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  ps2_state_t state, state_n;
  logic fall, data_s, good, bad, brk, brk_n, code_valid_n, parity, parity_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n, kd_n;
  logic [TW-1:0] tcnt, tcnt_n;
  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .fall(fall),
    .data_s(data_s)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      parity <= 1'b0;
      tcnt <= '0;
      brk <= 1'b0;
      keyboard_data <= PS2_NONE;
      code_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg <= shreg_n;
      parity <= parity_n;
      tcnt <= tcnt_n;
      brk <= brk_n;
      keyboard_data <= kd_n;
      code_valid <= code_valid_n;
      frame_err <= bad;
    end
  end
  always_comb begin
    state_n = state;
    bit_cnt_n = bit_cnt;
    shreg_n = shreg;
    parity_n = parity;
    tcnt_n = '0;
    good = 1'b0;
    bad = 1'b0;
    if (fall) begin
      case (state)
        IDLE: begin
          state_n = data_s ? IDLE : DATA;
          bit_cnt_n = '0;
        end
        DATA: begin
          shreg_n = {data_s, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          state_n = bit_cnt == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          parity_n = data_s;
          state_n = STOP;
        end
        default: begin
          state_n = IDLE;
          good = data_s & ^{shreg, parity};
          bad = ~good;
        end
      endcase
    end else if (state != IDLE) begin
      bad = tcnt == TW'(TIMEOUT_CYCLES - 1);
      state_n = bad ? IDLE : state;
      tcnt_n = tcnt + TW'(1);
    end
  end
`ifdef PS2_EXTENDED_EN
  logic ext, ext_n;
  always_ff @(posedge clk) begin
    if (rst) ext <= 1'b0;
    else ext <= ext_n;
  end
`endif
  always_comb begin
    kd_n = keyboard_data;
    brk_n = brk;
    code_valid_n = 1'b0;
`ifdef PS2_EXTENDED_EN
    ext_n = ext;
`endif
    if (good) begin
      if (shreg == PS2_BREAK) brk_n = 1'b1;
`ifdef PS2_EXTENDED_EN
      else if (shreg == PS2_EXT) ext_n = 1'b1;
      else if (ext) begin
        ext_n = 1'b0;
        brk_n = 1'b0;
      end
`else
      else if (shreg == PS2_EXT) brk_n = brk;
`endif
      else if (brk) begin
        brk_n = 1'b0;
        kd_n = shreg == keyboard_data ? PS2_NONE : keyboard_data;
      end else begin
        kd_n = shreg;
        code_valid_n = 1'b1;
      end
    end
  end
endmodule
